// File: rtl/udp_mc_pkt_send.sv
// Multi-channel UDP/IPv4 frame transmitter for an 8-bit GMII-style TX path.
// Round-robin arbitration, minimum-frame padding, IP checksum and Ethernet FCS.
module udp_mc_pkt_send #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MAX_LEN   = 1472,
    parameter logic [7:0]  TTL       = 8'hC8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [47:0]            i_dst_mac,
    input  logic [47:0]            i_src_mac,
    input  logic [31:0]            i_src_ip,
    input  logic [31:0]            i_dst_ip,
    input  logic [15:0]            i_src_port,
    input  logic [NUM_CH*16-1:0]   i_dst_port,
    input  logic [NUM_CH*16-1:0]   i_data_len,
    input  logic [NUM_CH-1:0]      i_req,
    output logic [NUM_CH-1:0]      o_gnt,
    input  logic [NUM_CH*8-1:0]    i_data,
    output logic [NUM_CH-1:0]      o_rd,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_en,
    output logic                   o_busy,
    output logic [15:0]            o_ip_id
);

    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned HDR_W    = 42 * 8;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        cnt, cnt_nxt;
    logic [15:0]        len;
    logic [HDR_W-1:0]   hdr;
    logic [31:0]        crc;
    logic [CH_W-1:0]    gnt_idx, rr_start;
    logic [7:0]         tx_data_nxt;
    logic               tx_en_nxt;

    logic               arb_found;
    logic [CH_W-1:0]    arb_idx;
    logic [CH_W:0]      cand;
    logic [15:0]        len_sel, len_clamp, tot_len, udp_len, port_sel, csum;
    logic [31:0]        sum32, fold1;
    logic [7:0]         pay_byte;
    logic [31:0]        fcs;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Round-robin search starting at the channel after the last one served
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_start} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!arb_found && (|(i_req & (NUM_CH'(1) << cand)))) begin
                arb_found = 1'b1;
                arb_idx   = cand[CH_W-1:0];
            end
        end
    end

    // Header fields and checksum for the channel being granted
    always_comb begin
        len_sel   = 16'(i_data_len >> {arb_idx, 4'b0000});
        port_sel  = 16'(i_dst_port >> {arb_idx, 4'b0000});
        len_clamp = (len_sel > 16'(MAX_LEN)) ? 16'(MAX_LEN) : len_sel;
        tot_len   = len_clamp + 16'd28;
        udp_len   = len_clamp + 16'd8;
        sum32     = 32'h0000_4500 + 32'(tot_len) + 32'(o_ip_id) + 32'({TTL, 8'h11})
                  + 32'(i_src_ip[31:16]) + 32'(i_src_ip[15:0])
                  + 32'(i_dst_ip[31:16]) + 32'(i_dst_ip[15:0]);
        fold1     = 32'(sum32[15:0]) + 32'(sum32[31:16]);
        csum      = ~(fold1[15:0] + fold1[31:16]);
    end

    assign pay_byte = 8'(i_data >> {gnt_idx, 3'b000});
    assign fcs      = ~crc;
    assign o_rd     = (state == S_PAY && !rst) ? o_gnt : '0;

    // Next state, counter and the TX byte to register
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 16'd1;
        tx_en_nxt   = 1'b0;
        tx_data_nxt = 8'h00;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (|i_req) state_nxt = S_ARB;
            end
            S_ARB: begin
                cnt_nxt   = '0;
                state_nxt = arb_found ? S_PRE : S_IDLE;
            end
            S_PRE: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = (cnt == 16'd7) ? 8'hD5 : 8'h55;
                if (cnt == 16'd7) begin
                    cnt_nxt   = '0;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = hdr[HDR_W-1 -: 8];
                if (cnt == 16'd41) begin
                    cnt_nxt   = '0;
                    state_nxt = (len == 16'd0) ? S_PAD : S_PAY;
                end
            end
            S_PAY: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = pay_byte;
                if (cnt == len - 16'd1) begin
                    cnt_nxt   = '0;
                    state_nxt = (len < 16'd18) ? S_PAD : S_FCS;
                end
            end
            S_PAD: begin
                tx_en_nxt = 1'b1;
                if (cnt == 16'd17 - len) begin
                    cnt_nxt   = '0;
                    state_nxt = S_FCS;
                end
            end
            S_FCS: begin
                tx_en_nxt   = 1'b1;
                tx_data_nxt = 8'(fcs >> {cnt[1:0], 3'b000});
                if (cnt == 16'd3) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IFG;
                end
            end
            S_IFG: begin
                if (cnt == 16'(IFG_BYTES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            o_tx_en   <= 1'b0;
            o_tx_data <= 8'h00;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_tx_en   <= tx_en_nxt;
            o_tx_data <= tx_data_nxt;
            o_busy    <= (state_nxt != S_IDLE);
        end
    end

    // Per-frame context: grant, header shifter, CRC, RR pointer and IP ID
    always_ff @(posedge clk) begin
        if (rst) begin
            o_gnt    <= '0;
            gnt_idx  <= '0;
            rr_start <= '0;
            o_ip_id  <= '0;
            len      <= '0;
            hdr      <= '0;
            crc      <= CRC_INIT;
        end else begin
            if (state == S_ARB && arb_found) begin
                o_gnt   <= NUM_CH'(1) << arb_idx;
                gnt_idx <= arb_idx;
                len     <= len_clamp;
                crc     <= CRC_INIT;
                hdr     <= {i_dst_mac, i_src_mac, 16'h0800,
                            8'h45, 8'h00, tot_len, o_ip_id, 16'h0000, TTL, 8'h11, csum,
                            i_src_ip, i_dst_ip,
                            i_src_port, port_sel, udp_len, 16'h0000};
            end
            if (state == S_HDR) begin
                hdr <= {hdr[HDR_W-9:0], 8'h00};
            end
            if (state == S_HDR || state == S_PAY || state == S_PAD) begin
                crc <= crc_step(crc, tx_data_nxt);
            end
            if (state == S_FCS && cnt == 16'd3) begin
                o_gnt    <= '0;
                rr_start <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
                o_ip_id  <= o_ip_id + 16'd1;
            end
        end
    end

endmodule
